// File: rtl/asic_top.sv
// asic_top: UART-to-GPIO bridge behind bidirectional pads.
// RX bytes drive a 32-bit GPIO word and are echoed on the TX pad.
module asic_top #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200
) (
  input  logic sys_clk_i_pad,
  input  logic rst_n_pad,
  input  logic ip_sel_pad0,
  input  logic ip_sel_pad1,
  input  logic ip_sel_pad2,
  inout  wire  io_pad0,
  inout  wire  io_pad1,
  inout  wire  io_pad2,
  inout  wire  io_pad3,
  inout  wire  io_pad4,
  inout  wire  io_pad5,
  inout  wire  io_pad6,
  inout  wire  io_pad7,
  inout  wire  io_pad8,
  inout  wire  io_pad9,
  inout  wire  io_pad10,
  inout  wire  io_pad11,
  inout  wire  io_pad12,
  inout  wire  io_pad13,
  inout  wire  io_pad14,
  inout  wire  io_pad15,
  inout  wire  io_pad16,
  inout  wire  io_pad17,
  inout  wire  io_pad18,
  inout  wire  io_pad19,
  inout  wire  io_pad20,
  inout  wire  io_pad21,
  inout  wire  io_pad22,
  inout  wire  io_pad23,
  inout  wire  io_pad24,
  inout  wire  io_pad25,
  inout  wire  io_pad26,
  inout  wire  io_pad27,
  inout  wire  io_pad28,
  inout  wire  io_pad29,
  inout  wire  io_pad30,
  inout  wire  io_pad31,
  inout  wire  io_pad32,
  inout  wire  io_pad33,
  inout  wire  io_pad34,
  inout  wire  io_pad35,
  inout  wire  io_pad36,
  inout  wire  io_pad37,
  inout  wire  io_pad38,
  inout  wire  io_pad39,
  inout  wire  io_pad40,
  inout  wire  io_pad41,
  inout  wire  io_pad42,
  inout  wire  io_pad43,
  inout  wire  io_pad44,
  inout  wire  io_pad45,
  inout  wire  io_pad46,
  inout  wire  io_pad47,
  inout  wire  io_pad48,
  inout  wire  io_pad49,
  inout  wire  io_pad50,
  inout  wire  io_pad51,
  inout  wire  io_pad52,
  inout  wire  io_pad53,
  inout  wire  io_pad54,
  inout  wire  io_pad55,
  inout  wire  io_pad56,
  inout  wire  io_pad57,
  inout  wire  io_pad58,
  inout  wire  io_pad59,
  inout  wire  io_pad60,
  inout  wire  io_pad61,
  inout  wire  io_pad62,
  inout  wire  io_pad63,
  inout  wire  io_pad64,
  inout  wire  io_pad65,
  inout  wire  io_pad66,
  inout  wire  io_pad67,
  inout  wire  io_pad68,
  inout  wire  io_pad69,
  inout  wire  io_pad70,
  inout  wire  io_pad71,
  inout  wire  io_pad72,
  inout  wire  io_pad73,
  inout  wire  io_pad74,
  inout  wire  io_pad75,
  inout  wire  io_pad76,
  inout  wire  io_pad77,
  inout  wire  io_pad78,
  inout  wire  io_pad79,
  inout  wire  io_pad80,
  inout  wire  io_pad81,
  output logic sys_clk_o_pad
);

  localparam int CPB  = CLK_FREQ_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  logic          clk;
  logic [2:0]    ip_sel;
  logic          gpio_oe;
  logic          tx_en;
  logic          rx;

  logic          rx_s1_q, rx_s1_d;
  logic          rx_s2_q, rx_s2_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;
  logic [31:0]   gpio_q, gpio_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          tx_o_q, tx_o_d;

  assign clk     = sys_clk_i_pad;
  assign ip_sel  = {ip_sel_pad2, ip_sel_pad1, ip_sel_pad0};
  assign gpio_oe = ~ip_sel[2] & ~(ip_sel[1] & ip_sel[0]);
  assign tx_en   = (ip_sel[2:1] == 2'b00);
  assign rx      = rx_s2_q;

  assign sys_clk_o_pad = sys_clk_i_pad;

  // two-flop synchronizer on the RX pad
  always_comb begin
    rx_s1_d = io_pad58;
    rx_s2_d = rx_s1_q;
  end

  // RX frame decoder: mid-bit sampling, framing-error lockout
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CW'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CW'(CPB - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CW'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx;
          rx_state_d = rx ? RX_IDLE : RX_ERR;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_ERR: begin
        if (rx) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // GPIO word update by mode
  always_comb begin
    gpio_d = gpio_q;
    case (ip_sel)
      3'b000: if (rx_valid_q) gpio_d = {gpio_q[23:0], rx_sh_q};
      3'b001: if (rx_valid_q) gpio_d = {24'h0, rx_sh_q};
      3'b010: gpio_d = gpio_q + 32'd1;
      default: gpio_d = gpio_q;
    endcase
  end

  // TX echo with a one-deep, overwritable pending slot
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    tx_o_d     = 1'b1;
    if (!tx_en) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      pend_v_d   = 1'b0;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (pend_v_q) begin
            tx_sh_d    = pend_q;
            pend_v_d   = 1'b0;
            tx_cnt_d   = '0;
            tx_state_d = TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == CW'(CPB - 1)) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == CW'(CPB - 1)) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_d = TX_STOP;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == CW'(CPB - 1)) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
      if (rx_valid_q) begin
        pend_d   = rx_sh_q;
        pend_v_d = 1'b1;
      end
      unique case (tx_state_d)
        TX_START: tx_o_d = 1'b0;
        TX_DATA:  tx_o_d = tx_sh_d[0];
        default:  tx_o_d = 1'b1;
      endcase
    end
  end

  // state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n_pad) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      gpio_q     <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      tx_o_q     <= 1'b1;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      gpio_q     <= gpio_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      tx_o_q     <= tx_o_d;
    end
  end

  pullup u_pu58 (io_pad58);

  assign io_pad59 = tx_o_q;

  assign io_pad0  = gpio_oe ? gpio_q[0]  : 1'bz;
  assign io_pad1  = gpio_oe ? gpio_q[1]  : 1'bz;
  assign io_pad2  = gpio_oe ? gpio_q[2]  : 1'bz;
  assign io_pad3  = gpio_oe ? gpio_q[3]  : 1'bz;
  assign io_pad4  = gpio_oe ? gpio_q[4]  : 1'bz;
  assign io_pad5  = gpio_oe ? gpio_q[5]  : 1'bz;
  assign io_pad6  = gpio_oe ? gpio_q[6]  : 1'bz;
  assign io_pad7  = gpio_oe ? gpio_q[7]  : 1'bz;
  assign io_pad8  = gpio_oe ? gpio_q[8]  : 1'bz;
  assign io_pad9  = gpio_oe ? gpio_q[9]  : 1'bz;
  assign io_pad10 = gpio_oe ? gpio_q[10] : 1'bz;
  assign io_pad11 = gpio_oe ? gpio_q[11] : 1'bz;
  assign io_pad12 = gpio_oe ? gpio_q[12] : 1'bz;
  assign io_pad13 = gpio_oe ? gpio_q[13] : 1'bz;
  assign io_pad14 = gpio_oe ? gpio_q[14] : 1'bz;
  assign io_pad15 = gpio_oe ? gpio_q[15] : 1'bz;
  assign io_pad16 = gpio_oe ? gpio_q[16] : 1'bz;
  assign io_pad17 = gpio_oe ? gpio_q[17] : 1'bz;
  assign io_pad18 = gpio_oe ? gpio_q[18] : 1'bz;
  assign io_pad19 = gpio_oe ? gpio_q[19] : 1'bz;
  assign io_pad20 = gpio_oe ? gpio_q[20] : 1'bz;
  assign io_pad21 = gpio_oe ? gpio_q[21] : 1'bz;
  assign io_pad22 = gpio_oe ? gpio_q[22] : 1'bz;
  assign io_pad23 = gpio_oe ? gpio_q[23] : 1'bz;
  assign io_pad24 = gpio_oe ? gpio_q[24] : 1'bz;
  assign io_pad25 = gpio_oe ? gpio_q[25] : 1'bz;
  assign io_pad26 = gpio_oe ? gpio_q[26] : 1'bz;
  assign io_pad27 = gpio_oe ? gpio_q[27] : 1'bz;
  assign io_pad28 = gpio_oe ? gpio_q[28] : 1'bz;
  assign io_pad29 = gpio_oe ? gpio_q[29] : 1'bz;
  assign io_pad30 = gpio_oe ? gpio_q[30] : 1'bz;
  assign io_pad31 = gpio_oe ? gpio_q[31] : 1'bz;

  assign io_pad32 = 1'bz;
  assign io_pad33 = 1'bz;
  assign io_pad34 = 1'bz;
  assign io_pad35 = 1'bz;
  assign io_pad36 = 1'bz;
  assign io_pad37 = 1'bz;
  assign io_pad38 = 1'bz;
  assign io_pad39 = 1'bz;
  assign io_pad40 = 1'bz;
  assign io_pad41 = 1'bz;
  assign io_pad42 = 1'bz;
  assign io_pad43 = 1'bz;
  assign io_pad44 = 1'bz;
  assign io_pad45 = 1'bz;
  assign io_pad46 = 1'bz;
  assign io_pad47 = 1'bz;
  assign io_pad48 = 1'bz;
  assign io_pad49 = 1'bz;
  assign io_pad50 = 1'bz;
  assign io_pad51 = 1'bz;
  assign io_pad52 = 1'bz;
  assign io_pad53 = 1'bz;
  assign io_pad54 = 1'bz;
  assign io_pad55 = 1'bz;
  assign io_pad56 = 1'bz;
  assign io_pad57 = 1'bz;
  assign io_pad60 = 1'bz;
  assign io_pad61 = 1'bz;
  assign io_pad62 = 1'bz;
  assign io_pad63 = 1'bz;
  assign io_pad64 = 1'bz;
  assign io_pad65 = 1'bz;
  assign io_pad66 = 1'bz;
  assign io_pad67 = 1'bz;
  assign io_pad68 = 1'bz;
  assign io_pad69 = 1'bz;
  assign io_pad70 = 1'bz;
  assign io_pad71 = 1'bz;
  assign io_pad72 = 1'bz;
  assign io_pad73 = 1'bz;
  assign io_pad74 = 1'bz;
  assign io_pad75 = 1'bz;
  assign io_pad76 = 1'bz;
  assign io_pad77 = 1'bz;
  assign io_pad78 = 1'bz;
  assign io_pad79 = 1'bz;
  assign io_pad80 = 1'bz;
  assign io_pad81 = 1'bz;

endmodule

// File: tb/tb_asic_top.sv
// tb_asic_top: directed bench for the UART-to-GPIO bridge.
// Board pull-ups make a released pad read as 1.
module tb_asic_top;

  localparam int CPB = 868;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] sel;
  logic rx_line;
  wire  clk_o;

  tri1 p0, p1, p2, p3, p4, p5, p6, p7;
  tri1 p8, p9, p10, p11, p12, p13, p14, p15;
  tri1 p16, p17, p18, p19, p20, p21, p22, p23;
  tri1 p24, p25, p26, p27, p28, p29, p30, p31;
  tri1 p32, p33, p34, p35, p36, p37, p38, p39;
  tri1 p40, p41, p42, p43, p44, p45, p46, p47;
  tri1 p48, p49, p50, p51, p52, p53, p54, p55;
  tri1 p56, p57, p60, p61, p62, p63, p64, p65;
  tri1 p66, p67, p68, p69, p70, p71, p72, p73;
  tri1 p74, p75, p76, p77, p78, p79, p80, p81;
  wire p58;
  wire p59;

  assign p58 = rx_line;

  wire [31:0] gp = {p31, p30, p29, p28, p27, p26, p25, p24,
                    p23, p22, p21, p20, p19, p18, p17, p16,
                    p15, p14, p13, p12, p11, p10, p9, p8,
                    p7, p6, p5, p4, p3, p2, p1, p0};

  wire [47:0] unused = {p32, p33, p34, p35, p36, p37, p38, p39,
                        p40, p41, p42, p43, p44, p45, p46, p47,
                        p48, p49, p50, p51, p52, p53, p54, p55,
                        p56, p57, p60, p61, p62, p63, p64, p65,
                        p66, p67, p68, p69, p70, p71, p72, p73,
                        p74, p75, p76, p77, p78, p79, p80, p81};

  always #5 clk = ~clk;

  asic_top dut (
    .sys_clk_i_pad(clk), .rst_n_pad(rst_n),
    .ip_sel_pad0(sel[0]), .ip_sel_pad1(sel[1]), .ip_sel_pad2(sel[2]),
    .io_pad0(p0), .io_pad1(p1), .io_pad2(p2), .io_pad3(p3),
    .io_pad4(p4), .io_pad5(p5), .io_pad6(p6), .io_pad7(p7),
    .io_pad8(p8), .io_pad9(p9), .io_pad10(p10), .io_pad11(p11),
    .io_pad12(p12), .io_pad13(p13), .io_pad14(p14), .io_pad15(p15),
    .io_pad16(p16), .io_pad17(p17), .io_pad18(p18), .io_pad19(p19),
    .io_pad20(p20), .io_pad21(p21), .io_pad22(p22), .io_pad23(p23),
    .io_pad24(p24), .io_pad25(p25), .io_pad26(p26), .io_pad27(p27),
    .io_pad28(p28), .io_pad29(p29), .io_pad30(p30), .io_pad31(p31),
    .io_pad32(p32), .io_pad33(p33), .io_pad34(p34), .io_pad35(p35),
    .io_pad36(p36), .io_pad37(p37), .io_pad38(p38), .io_pad39(p39),
    .io_pad40(p40), .io_pad41(p41), .io_pad42(p42), .io_pad43(p43),
    .io_pad44(p44), .io_pad45(p45), .io_pad46(p46), .io_pad47(p47),
    .io_pad48(p48), .io_pad49(p49), .io_pad50(p50), .io_pad51(p51),
    .io_pad52(p52), .io_pad53(p53), .io_pad54(p54), .io_pad55(p55),
    .io_pad56(p56), .io_pad57(p57), .io_pad58(p58), .io_pad59(p59),
    .io_pad60(p60), .io_pad61(p61), .io_pad62(p62), .io_pad63(p63),
    .io_pad64(p64), .io_pad65(p65), .io_pad66(p66), .io_pad67(p67),
    .io_pad68(p68), .io_pad69(p69), .io_pad70(p70), .io_pad71(p71),
    .io_pad72(p72), .io_pad73(p73), .io_pad74(p74), .io_pad75(p75),
    .io_pad76(p76), .io_pad77(p77), .io_pad78(p78), .io_pad79(p79),
    .io_pad80(p80), .io_pad81(p81),
    .sys_clk_o_pad(clk_o)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [9:0]  txq[$];
  logic [31:0] model;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      bit_time();
    end
    rx_line = stop;
    bit_time();
    rx_line = 1'b1;
  endtask

  task automatic tx_capture();
    int n;
    logic [9:0] fr;
    n = 0;
    fr = '0;
    while (p59 !== 1'b0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", {47'b0, n < 40 * CPB}, 48'd1);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      fr[i] = p59;
      if (i < 9) bit_time();
    end
    chk("tx_frame", {38'b0, fr}, {38'b0, txq.pop_front()});
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 3'b000;
    rx_line = 1'b1;
    model   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio", {16'b0, gp}, 48'h0);
    chk("rst_tx", {47'b0, p59}, 48'd1);
    chk("rst_unused_z", unused, {48{1'b1}});
    chk("clk_o_hi", {47'b0, clk_o}, 48'd1);
    @(negedge clk);
    #1;
    chk("clk_o_lo", {47'b0, clk_o}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // mode 000: back-to-back shift-in of 1,2,3,4
    for (int i = 1; i <= 4; i++) begin
      model = {model[23:0], 8'(i)};
      exp_q.push_back(model);
      send_frame(8'(i), 1'b1);
      chk("shift_in", {16'b0, gp}, {16'b0, exp_q.pop_front()});
    end
    repeat (12 * CPB) @(negedge clk);

    // mode 001: load and echo 0xA5
    sel = 3'b001;
    model = 32'h0000_00A5;
    exp_q.push_back(model);
    txq.push_back({1'b1, 8'hA5, 1'b0});
    fork
      send_frame(8'hA5, 1'b1);
      tx_capture();
    join
    chk("mode1_load", {16'b0, gp}, {16'b0, exp_q.pop_front()});

    // short low glitch is a false start
    rx_line = 1'b0;
    repeat (20) @(negedge clk);
    rx_line = 1'b1;
    repeat (2000) @(negedge clk);
    chk("glitch", {16'b0, gp}, {16'b0, model});

    // bad stop bit is dropped, next frame is taken
    send_frame(8'h3C, 1'b0);
    bit_time();
    chk("frame_err", {16'b0, gp}, {16'b0, model});
    model = 32'h0000_005A;
    exp_q.push_back(model);
    send_frame(8'h5A, 1'b1);
    chk("after_err", {16'b0, gp}, {16'b0, exp_q.pop_front()});

    // mode 111: GPIO released, value retained
    sel = 3'b111;
    @(posedge clk);
    #1;
    chk("gpio_hiz", {16'b0, gp}, {16'b0, 32'hFFFF_FFFF});
    chk("unused_z", unused, {48{1'b1}});
    chk("tx_idle_111", {47'b0, p59}, 48'd1);
    repeat (50) @(negedge clk);
    sel = 3'b000;
    @(posedge clk);
    #1;
    chk("restore", {16'b0, gp}, {16'b0, model});

    // mode 010: free-running count from the held value
    @(negedge clk);
    sel = 3'b010;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("count", {16'b0, gp}, {16'b0, model + 32'(k)});
    end

    // reset in the middle of a TX frame
    @(negedge clk);
    sel = 3'b001;
    model = 32'h0;
    exp_q.push_back(model);
    send_frame(8'h00, 1'b1);
    chk("zero_byte", {16'b0, gp}, {16'b0, exp_q.pop_front()});
    chk("tx_busy", {47'b0, p59}, 48'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tx_abort", {47'b0, p59}, 48'd1);
    chk("rst_gpio_mid", {16'b0, gp}, 48'h0);
    chk("sb_empty", 48'(exp_q.size()), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
